track_cell_reader: RTL and testbench
====================================

Name: track_cell_reader

Overview:
- Consumer side of the mouse-drawing capture path.
- Accepts a finished 52x52 handwriting bitmap plus its target Sudoku block index, one capture per in_valid pulse.
- Scans the bitmap in 4x4-pixel cells and streams 169 per-cell ink counts and thresholded bits to the digit classifier over a valid/ready handshake.
- Sits between the mouse-drawing block and the recognizer.

Parameters:
- SIZE, 52, bitmap edge in pixels; track bit index = y*SIZE + x.
- CELL, 4, cell edge in pixels; GRID = SIZE/CELL = 13 is a derived localparam. SIZE must be a multiple of CELL.
- THRESH, 2, minimum set pixels in a cell for out_bit=1.
- CW, 5, count width; must hold CELL*CELL (16).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  one-cycle pulse: track/in_block_pos are valid
- in_block_pos  in  7  Sudoku block index 0..80
- track  in  SIZE*SIZE (2704)  bitmap, bit y*SIZE+x
- in_ready  out  1  high only in IDLE
- out_valid  out  1  cell beat valid
- out_ready  in  1  downstream accepts beat
- out_count  out  CW  set pixels in current cell, 0..16
- out_bit  out  1  out_count >= THRESH
- out_index  out  8  cell index cy*GRID+cx, 0..168
- out_last  out  1  high with index 168
- block_pos  out  7  latched in_block_pos
- busy  out  1  high in LOAD and EMIT
- done  out  1  one-cycle pulse after the last beat is accepted

Behaviour:
- Reset is asynchronous and active-low: state=IDLE, and every output, the internal index and the latched track are 0. Because in_ready is combinational from state, it is 1 immediately after reset.
- IDLE:
  - in_ready=1.
  - On in_valid, latch track into track_q and in_block_pos into block_pos, then go to LOAD.
  - in_valid while not IDLE is ignored with no side effects. The captured bitmap is never updated mid-stream.
- LOAD (1 cycle):
  - Register the count for cell 0 into out_count/out_bit/out_index.
  - Set out_valid=1 and go to EMIT.
  - First beat is visible 2 cycles after the in_valid edge.
- EMIT:
  - out_valid stays high.
  - out_count/out_bit/out_index/out_last stay stable while out_ready=0.
  - On out_valid&&out_ready with index<168: index+1 is loaded the same edge, so back-to-back beats run at 1 per clock.
  - On a handshake at index 168: out_valid->0, done=1 for one cycle, go to IDLE.
  - in_ready returns to 1 the cycle done is high.
- Cell count:
  - Popcount of track_q bits (cy*CELL+r)*SIZE + cx*CELL+c, for r,c in 0..CELL-1.
  - Computed combinationally from the next index and registered on load.
  - cy = index / GRID, cx = index % GRID, kept as separate row/column counters to avoid division: cx wraps 12->0 and increments cy.
- Widths:
  - out_count is zero-extended to CW.
  - Comparison with THRESH is unsigned.
  - out_index never exceeds 168 and never wraps past it.
- Simultaneous events:
  - in_valid in the same cycle as the final handshake is dropped, because in_ready=0 that cycle.
  - out_ready may be held high continuously.
- Reset mid-stream aborts immediately. No done pulse is produced, and the partial stream is not resumed.

Optional Feature:
TRACK_MIRROR_EN
- Defined: the mouse origin is at the bottom-right, so the cell scanned for beat index i is (GRID-1-cy, GRID-1-cx). The stream is then upright, top-left first. out_index still reports the beat number 0..168.
- Undefined: cells are scanned in raw bit order as described above.

Test Plan:
- All-zero track, in_valid pulse, out_ready=1 -> out_valid 2 cycles later; 169 consecutive beats, all out_count=0/out_bit=0; out_last only at index 168; done one cycle after; in_ready=1 with done.
- Only bit 0 set -> beat 0: count=1, bit=0 (THRESH=2); all other beats 0.
- Bits (48..51)*52+(48..51) set -> beat 168: count=16, bit=1; others 0. With TRACK_MIRROR_EN, the same data appears on beat 0.
- Bits 53 and 54 set, out_ready low for 10 cycles when beat 0 is presented -> outputs held stable, count=2, bit=1; stream resumes on out_ready.
- in_valid with a different track and in_block_pos=40 at beat 50 -> ignored; block_pos and the stream remain those of the first capture.
- rst_n low at beat 80 -> all outputs 0 asynchronously, no done pulse; after release, a new capture streams from index 0.

Source files
------------

// File: rtl/track_cell_reader.sv
// Streams the 169 per-cell ink counts of a captured 52x52 handwriting bitmap to the classifier.
// Optional define TRACK_MIRROR_EN: the bitmap origin is bottom-right, so cells are read rotated 180 degrees.
module track_cell_reader #(
   parameter int SIZE   = 52,
   parameter int CELL   = 4,
   parameter int THRESH = 2,
   parameter int CW     = 5
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   input  logic [6:0]             in_block_pos,
   input  logic [SIZE*SIZE-1:0]   track,
   output logic                   in_ready,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [CW-1:0]          out_count,
   output logic                   out_bit,
   output logic [7:0]             out_index,
   output logic                   out_last,
   output logic [6:0]             block_pos,
   output logic                   busy,
   output logic                   done
);

   localparam int GRID = SIZE / CELL;
   localparam int NPIX = SIZE * SIZE;
   localparam int TW   = $clog2(NPIX);
   localparam int GW   = $clog2(GRID);
   localparam int LAST = GRID * GRID - 1;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EMIT} state_t;

   state_t          r_state, w_next;
   logic [NPIX-1:0] r_track;
   logic [6:0]      r_bpos;
   logic [GW-1:0]   r_cx, r_cy;
   logic [7:0]      r_idx;
   logic [CW-1:0]   r_count;
   logic            r_bit, r_last, r_valid, r_done;

   logic            w_ld, w_fin;
   logic [GW-1:0]   w_nx, w_ny, w_sx, w_sy;
   logic [7:0]      w_nidx;
   logic [TW-1:0]   w_base, w_bi;
   logic [CW-1:0]   w_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      w_ld   = 1'b0;
      w_fin  = 1'b0;
      case (r_state)
         S_IDLE: if (in_valid) w_next = S_LOAD;
         S_LOAD: begin
            w_ld   = 1'b1;
            w_next = S_EMIT;
         end
         S_EMIT: begin
            if (r_valid && out_ready) begin
               if (r_idx == 8'(LAST)) begin
                  w_fin  = 1'b1;
                  w_next = S_IDLE;
               end else begin
                  w_ld = 1'b1;
               end
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Row/column counters of the cell about to be loaded; avoids dividing the index by GRID.
   always_comb begin
      w_nx   = r_cx + GW'(1);
      w_ny   = r_cy;
      w_nidx = r_idx + 8'd1;
      if (r_state == S_LOAD) begin
         w_nx   = '0;
         w_ny   = '0;
         w_nidx = '0;
      end else if (r_cx == GW'(GRID - 1)) begin
         w_nx = '0;
         w_ny = r_cy + GW'(1);
      end
   end

`ifdef TRACK_MIRROR_EN
   assign w_sx = GW'(GRID - 1) - w_nx;
   assign w_sy = GW'(GRID - 1) - w_ny;
`else
   assign w_sx = w_nx;
   assign w_sy = w_ny;
`endif

   assign w_base = TW'(w_sy) * TW'(CELL * SIZE) + TW'(w_sx) * TW'(CELL);

   always_comb begin
      w_count = '0;
      w_bi    = '0;
      for (int r = 0; r < CELL; r++) begin
         for (int c = 0; c < CELL; c++) begin
            w_bi    = w_base + TW'(r * SIZE + c);
            w_count = w_count + CW'(r_track[w_bi]);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_track <= '0;
         r_bpos  <= '0;
         r_cx    <= '0;
         r_cy    <= '0;
         r_idx   <= '0;
         r_count <= '0;
         r_bit   <= 1'b0;
         r_last  <= 1'b0;
         r_valid <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         if (r_state == S_IDLE && in_valid) begin
            r_track <= track;
            r_bpos  <= in_block_pos;
         end
         r_done <= w_fin;
         if (w_ld) begin
            r_cx    <= w_nx;
            r_cy    <= w_ny;
            r_idx   <= w_nidx;
            r_count <= w_count;
            r_bit   <= (w_count >= CW'(THRESH));
            r_last  <= (w_nidx == 8'(LAST));
            r_valid <= 1'b1;
         end else if (w_fin) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign in_ready  = (r_state == S_IDLE);
   assign busy      = (r_state != S_IDLE);
   assign out_valid = r_valid;
   assign out_count = r_count;
   assign out_bit   = r_bit;
   assign out_index = r_idx;
   assign out_last  = r_last;
   assign block_pos = r_bpos;
   assign done      = r_done;

endmodule

// File: tb/tb_track_cell_reader.sv
// Randomized bench for track_cell_reader against a pixel-level cell popcount model.
module tb_track_cell_reader;
   localparam int S = 52;
   localparam int C = 4;
   localparam int G = S / C;
   localparam int N = S * S;
   localparam int TH = 2;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic [6:0]   in_block_pos = '0;
   logic [N-1:0] track = '0;
   logic         in_ready, out_valid, out_bit, out_last, busy, done;
   logic         out_ready = 1'b0;
   logic [4:0]   out_count;
   logic [7:0]   out_index;
   logic [6:0]   block_pos;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   track_cell_reader dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_block_pos(in_block_pos),
      .track(track), .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
      .out_count(out_count), .out_bit(out_bit), .out_index(out_index), .out_last(out_last),
      .block_pos(block_pos), .busy(busy), .done(done)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Ink count of the cell shown on beat i, straight from the pixel addressing rule.
   function automatic int mcount(input logic [N-1:0] t, input int i);
      int cy = i / G;
      int cx = i % G;
      int n = 0;
`ifdef TRACK_MIRROR_EN
      cy = G - 1 - cy;
      cx = G - 1 - cx;
`endif
      for (int r = 0; r < C; r++)
         for (int c = 0; c < C; c++)
            n += int'(t[(cy * C + r) * S + cx * C + c]);
      return n;
   endfunction

   function automatic logic [N-1:0] rnd_track(input int dens);
      logic [N-1:0] t;
      for (int k = 0; k < N; k++) t[k] = ($urandom % 100) < dens;
      return t;
   endfunction

   task automatic capture(input logic [N-1:0] trk, input logic [6:0] bp, input int rdy_pct,
                          input int stall0, input int inject_at, input int abort_at);
      int beat = 0;
      int cyc = 0;
      int stall = 0;
      bit injected = 0;
      logic rdy;
      @(negedge clk);
      chk("idle_ready", in_ready, 1);
      track = trk; in_block_pos = bp; in_valid = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      track = rnd_track(50);
      chk("load_novalid", out_valid, 0);
      chk("load_busy", busy, 1);
      chk("load_inready", in_ready, 0);
      @(negedge clk);
      while (beat < G * G && cyc < 4000) begin
         in_valid = 1'b0;
         chk("vld", out_valid, 1);
         chk("idx", out_index, beat);
         chk("cnt", out_count, mcount(trk, beat));
         chk("bit", out_bit, int'(mcount(trk, beat) >= TH));
         chk("last", out_last, int'(beat == G * G - 1));
         chk("bpos", block_pos, bp);
         if (beat == abort_at) begin
            rst_n = 1'b0;
            #1;
            chk("rst_vld", out_valid, 0);
            chk("rst_cnt", out_count, 0);
            chk("rst_idx", out_index, 0);
            chk("rst_bpos", block_pos, 0);
            chk("rst_busy", busy, 0);
            chk("rst_inready", in_ready, 1);
            @(negedge clk);
            rst_n = 1'b1;
            out_ready = 1'b0;
            repeat (3) begin
               @(negedge clk);
               chk("abort_nodone", done, 0);
               chk("abort_idle", busy, 0);
            end
            return;
         end
         if (stall0 != 0 && beat == 0 && stall < 10) begin
            rdy = 1'b0;
            stall++;
         end else begin
            rdy = ($urandom % 100) < rdy_pct;
         end
         if (beat == inject_at && !injected) begin
            injected = 1;
            in_valid = 1'b1;
            in_block_pos = 7'd40;
            if (beat == G * G - 1) rdy = 1'b1;
         end
         out_ready = rdy;
         if (rdy) beat++;
         cyc++;
         @(negedge clk);
      end
      in_valid = 1'b0;
      chk("timeout", beat, G * G);
      chk("done", done, 1);
      chk("done_inready", in_ready, 1);
      chk("done_novalid", out_valid, 0);
      out_ready = 1'b0;
      @(negedge clk);
      chk("done_pulse", done, 0);
      chk("post_idle", busy, 0);
      chk("post_novalid", out_valid, 0);
   endtask

   initial begin
      logic [N-1:0] t;
      #2;
      chk("r_vld", out_valid, 0);
      chk("r_ready", in_ready, 1);
      chk("r_busy", busy, 0);
      chk("r_done", done, 0);
      chk("r_idx", out_index, 0);
      @(negedge clk);
      rst_n = 1'b1;

      capture('0, 7'd3, 100, 0, -1, -1);
      t = '0; t[0] = 1'b1;
      capture(t, 7'd10, 100, 0, -1, -1);
      t = '0;
      for (int y = 48; y < 52; y++) for (int x = 48; x < 52; x++) t[y * S + x] = 1'b1;
      capture(t, 7'd80, 100, 0, -1, -1);
      t = '0; t[53] = 1'b1; t[54] = 1'b1;
      capture(t, 7'd5, 100, 1, -1, -1);
      capture(rnd_track(30), 7'd22, 60, 0, 50, -1);
      capture(rnd_track(20), 7'd61, 80, 0, -1, 80);
      capture(rnd_track(10), 7'd7, 70, 0, 168, -1);
      capture(rnd_track(60), 7'd79, 50, 0, -1, -1);
      capture(rnd_track(3), 7'd0, 100, 0, -1, -1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
